// File: rtl/edge_detect_if.sv
// edge_detect_if: grid/strobe input and edge-result outputs of the Sobel stage.
// EDGE_MAG_OUT_EN adds the saturated magnitude output edge_mag.
interface edge_detect_if
`ifdef EDGE_MAG_OUT_EN
  #(parameter int MAG_WIDTH = 8)
`endif
;
  logic [71:0] iGrid;
  logic        edgedetect_enable;
  logic        busy;
  logic        edge_valid;
  logic        edge_out;
  logic        overrun;
`ifdef EDGE_MAG_OUT_EN
  logic [MAG_WIDTH-1:0] edge_mag;
`endif
  modport master (
    output iGrid, edgedetect_enable,
    input  busy, edge_valid, edge_out, overrun
`ifdef EDGE_MAG_OUT_EN
    , input edge_mag
`endif
  );
  modport slave (
    input  iGrid, edgedetect_enable,
    output busy, edge_valid, edge_out, overrun
`ifdef EDGE_MAG_OUT_EN
    , output edge_mag
`endif
  );
endinterface

// File: rtl/edge_detect.sv
// edge_detect: 4-cycle Sobel |Gx|+|Gy| threshold on a 3x3 grid (IDLE/SOBEL/SUM/OUT).
// EDGE_MAG_OUT_EN adds a registered saturated magnitude output.
module edge_detect #(
  parameter logic [10:0] THRESH = 11'd128
`ifdef EDGE_MAG_OUT_EN
  , parameter int MAG_WIDTH = 8
`endif
) (
  input logic         clk,
  input logic         rst,
  edge_detect_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SOBEL, SUM, OUT} state_e;
  state_e      state_q, state_d;
  logic [71:0] grid_q;
  logic [7:0]  p [9];
  logic [10:0] gx_d, gy_d, gx_q, gy_q, ax, ay, sum_d, sum_q;
  logic        edge_q, valid_q, ovr_q;
  function automatic logic [10:0] w(input logic [7:0] v);
    return {3'b000, v};
  endfunction
  for (genvar g = 0; g < 9; g++) begin : g_px
    assign p[g] = grid_q[71-8*g -: 8];
  end
  // 11-bit wraparound is exact: true results lie in -1020..+1020
  always_comb begin
    state_d = (state_q == IDLE) ? (bus.edgedetect_enable ? SOBEL : IDLE) : state_e'(state_q + 2'd1);
    gx_d    = (w(p[2]) + (w(p[5]) << 1) + w(p[8])) - (w(p[0]) + (w(p[3]) << 1) + w(p[6]));
    gy_d    = (w(p[6]) + (w(p[7]) << 1) + w(p[8])) - (w(p[0]) + (w(p[1]) << 1) + w(p[2]));
    ax      = gx_q[10] ? -gx_q : gx_q;
    ay      = gy_q[10] ? -gy_q : gy_q;
    sum_d   = ax + ay;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grid_q  <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      sum_q   <= '0;
      edge_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.edgedetect_enable) grid_q <= bus.iGrid;
      if (state_q == SOBEL) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
      end
      if (state_q == SUM) sum_q <= sum_d;
      if (state_q == OUT) edge_q <= sum_q >= THRESH;
      valid_q <= state_q == OUT;
      if (state_q != IDLE && bus.edgedetect_enable) ovr_q <= 1'b1;
    end
  end
  assign bus.busy       = state_q != IDLE;
  assign bus.edge_valid = valid_q;
  assign bus.edge_out   = edge_q;
  assign bus.overrun    = ovr_q;
`ifdef EDGE_MAG_OUT_EN
  localparam logic [10:0] MAG_MAX = 11'((1 << MAG_WIDTH) - 1);
  logic [MAG_WIDTH-1:0] mag_q;
  always_ff @(posedge clk) begin
    if (rst) mag_q <= '0;
    else if (state_q == OUT) mag_q <= (sum_q > MAG_MAX) ? '1 : sum_q[MAG_WIDTH-1:0];
  end
  assign bus.edge_mag = mag_q;
`endif
endmodule

// File: tb/tb_edge_detect.sv
// tb_edge_detect: randomized + directed scoreboard bench for edge_detect.
module tb_edge_detect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  edge_detect_if bus ();
  edge_detect dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {int cyc; bit e; int mag;} exp_t;
  exp_t q[$];
  int cyc = 0, last_k = -100, checks = 0, errors = 0;
  bit exp_ovr = 0, held_e = 0;
  int held_mag = 0;
  always @(posedge clk) cyc = cyc + 1;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask
  function automatic logic [71:0] pack(input int v [9]);
    logic [71:0] g;
    for (int i = 0; i < 9; i++) g[71-8*i -: 8] = v[i][7:0];
    return g;
  endfunction
  // reference: Sobel from the stated formulas on plain integers
  function automatic int mag_of(input logic [71:0] g);
    int v [9];
    int gx, gy;
    for (int i = 0; i < 9; i++) v[i] = int'(g[71-8*i -: 8]);
    gx = (v[2] + 2*v[5] + v[8]) - (v[0] + 2*v[3] + v[6]);
    gy = (v[6] + 2*v[7] + v[8]) - (v[0] + 2*v[1] + v[2]);
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction
  task automatic step(input bit r, input bit e, input logic [71:0] g);
    int k, m;
    rst = r;
    bus.edgedetect_enable = e;
    bus.iGrid = e ? g : {$urandom, $urandom, 8'($urandom)};
    @(posedge clk);
    #1;
    k = cyc;
    if (r) begin
      q.delete();
      last_k = -100;
      exp_ovr = 0;
      held_e = 0;
      held_mag = 0;
    end else if (e) begin
      if (k >= last_k + 4) begin
        last_k = k;
        m = mag_of(g);
        q.push_back('{k + 3, m >= 128, m > 255 ? 255 : m});
      end else exp_ovr = 1;
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0);
  endtask
  task automatic shot(input int v [9]);
    step(0, 1, pack(v));
    idle(3);
  endtask
  always @(negedge clk) begin
    if (bus.edge_valid) begin
      if (q.size() == 0 || q[0].cyc != cyc) chk("unexpected_valid", 1, 0);
      else begin
        held_e = q[0].e;
        held_mag = q[0].mag;
        void'(q.pop_front());
        chk("valid_timing", 1, 1);
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      chk("missing_valid", 0, 1);
      void'(q.pop_front());
    end
    chk("edge_out", int'(bus.edge_out), int'(held_e));
`ifdef EDGE_MAG_OUT_EN
    chk("edge_mag", int'(bus.edge_mag), held_mag);
`endif
    chk("busy", int'(bus.busy), int'(cyc >= last_k && cyc <= last_k + 2));
    chk("overrun", int'(bus.overrun), int'(exp_ovr));
  end
  initial begin
    logic [71:0] g;
    int v [9];
    bus.edgedetect_enable = 1'b0;
    bus.iGrid = '0;
    step(1, 0, '0);
    step(1, 1, '1);
    idle(2);
    shot('{20, 20, 40, 60, 80, 100, 120, 144, 160});
    shot('{50, 50, 50, 50, 50, 50, 50, 50, 50});
    shot('{0, 0, 0, 0, 0, 64, 0, 0, 0});
    shot('{0, 0, 0, 0, 0, 63, 0, 0, 0});
    shot('{0, 0, 0, 64, 0, 0, 0, 0, 0});
    shot('{0, 255, 255, 0, 255, 255, 0, 255, 255});
    idle(2);
    step(0, 1, pack('{0, 0, 0, 0, 0, 200, 0, 0, 0}));
    idle(1);
    step(0, 1, pack('{0, 0, 0, 0, 0, 0, 0, 0, 0}));
    idle(6);
    step(0, 1, pack('{0, 0, 0, 0, 0, 200, 0, 0, 0}));
    idle(1);
    step(1, 0, '0);
    idle(3);
    shot('{0, 0, 0, 0, 0, 100, 0, 0, 0});
    idle(1);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 9; i++)
        case ($urandom_range(3))
          0: v[i] = 0;
          1: v[i] = 255;
          2: v[i] = $urandom_range(255);
          default: v[i] = $urandom_range(40);
        endcase
      g = pack(v);
      if ($urandom_range(49) == 0) step(1, $urandom_range(1) == 1, g);
      else step(0, $urandom_range(2) != 0, g);
    end
    idle(6);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
